// File: rtl/apb_bridge_controller.sv
// AHB-to-APB bridge sequencer: accepts one AHB address phase at a time,
// runs the APB SETUP/ACCESS phases and returns read data to AHB.
module apb_bridge_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  Hvalid,
  input  logic                  Hwrite,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Hreadyout,
  output logic [DATA_WIDTH-1:0] Hrdata,
  output logic [2:0]            Pselx,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic [DATA_WIDTH-1:0] Pwdata
);

  // state  | meaning
  // IDLE   | no transfer, ready to accept
  // WWAIT  | write accepted, capturing Hwdata
  // SETUP  | APB setup phase (Pselx set, Penable low)
  // ACCESS | APB access phase, may accept the next transfer
  typedef enum logic [1:0] {IDLE, WWAIT, SETUP, ACCESS} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            sel_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [2:0]            sel_dec;
  logic                  accept;

  // Three 64 MB windows starting at 0x8000_0000, selected by the top six address bits.
  always_comb begin
    sel_dec = 3'b000;
    case (Haddr[ADDR_WIDTH-1 -: 6])
      6'b100000: sel_dec = 3'b001;
      6'b100001: sel_dec = 3'b010;
      6'b100010: sel_dec = 3'b100;
      default:   sel_dec = 3'b000;
    endcase
  end

  assign accept = Hvalid && (sel_dec != 3'b000) && Hreadyout &&
                  ((state == IDLE) || (state == ACCESS));

  // Read data flows straight through during read ACCESS, otherwise the last captured value.
  assign Hrdata = ((state == ACCESS) && !Pwrite) ? Prdata : hrdata_q;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state     <= IDLE;
      Hreadyout <= 1'b1;
      Pselx     <= 3'b000;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      hrdata_q  <= '0;
      addr_q    <= '0;
      sel_q     <= 3'b000;
    end else begin
      case (state)
        IDLE, ACCESS: begin
          if ((state == ACCESS) && !Pwrite)
            hrdata_q <= Prdata;
          Penable <= 1'b0;
          if (accept) begin
            addr_q    <= Haddr;
            sel_q     <= sel_dec;
            Hreadyout <= 1'b0;
            if (Hwrite) begin
              state <= WWAIT;
              Pselx <= 3'b000;
            end else begin
              state  <= SETUP;
              Pselx  <= sel_dec;
              Paddr  <= Haddr;
              Pwrite <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            Pselx     <= 3'b000;
            Hreadyout <= 1'b1;
          end
        end
        WWAIT: begin
          state  <= SETUP;
          Pselx  <= sel_q;
          Paddr  <= addr_q;
          Pwrite <= 1'b1;
          Pwdata <= Hwdata;
        end
        SETUP: begin
          state     <= ACCESS;
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          Pselx     <= 3'b000;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Directed bench for apb_bridge_controller: reads, writes, back-to-back,
// out-of-range decode, input hold-off and asynchronous reset.
module tb_apb_bridge_controller;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hvalid;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Hreadyout;
  logic [31:0] Hrdata;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  int vectors = 0;
  int miscompares = 0;

  apb_bridge_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hvalid(Hvalid), .Hwrite(Hwrite),
    .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .Hreadyout(Hreadyout),
    .Hrdata(Hrdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata)
  );

  always #5 Hclk = ~Hclk;

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge Hclk);
    vectors++;
    if ({Hreadyout, Pselx, Penable, Pwrite} !== 6'b1_000_0_0) begin
      miscompares++;
      $display("FAIL reset_ctrl got rdy/sel/en/wr=%b%b%b%b exp 1 000 0 0", Hreadyout, Pselx, Penable, Pwrite);
    end
    vectors++;
    if ({Paddr, Pwdata, Hrdata} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data got paddr=%h pwdata=%h hrdata=%h exp 0", Paddr, Pwdata, Hrdata);
    end
  endtask

  task automatic test_read();
    step();
    Hvalid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010; Prdata = 32'h0000_00A5;
    step();
    Hvalid = 1'b0; Haddr = 32'h0;
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b001_0_0_0 || Paddr !== 32'h8000_0010) begin
      miscompares++;
      $display("FAIL read_setup got sel=%b en=%b wr=%b rdy=%b paddr=%h exp 001 0 0 0 80000010", Pselx, Penable, Pwrite, Hreadyout, Paddr);
    end
    step();
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Penable, Hreadyout} !== 5'b001_1_1 || Hrdata !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL read_access got sel=%b en=%b rdy=%b hrdata=%h exp 001 1 1 000000a5", Pselx, Penable, Hreadyout, Hrdata);
    end
    step();
    Prdata = 32'h0000_0077;
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1 || Hrdata !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL read_idle_hold got sel=%b en=%b rdy=%b hrdata=%h exp 000 0 1 000000a5", Pselx, Penable, Hreadyout, Hrdata);
    end
  endtask

  task automatic test_write();
    Hvalid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0020;
    step();
    Hvalid = 1'b0; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'hDEAD_BEEF;
    @(negedge Hclk);
    vectors++;
    if ({Hreadyout, Pselx, Penable} !== 5'b0_000_0) begin
      miscompares++;
      $display("FAIL write_wwait got rdy=%b sel=%b en=%b exp 0 000 0", Hreadyout, Pselx, Penable);
    end
    step();
    Hwdata = 32'h0;
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Pwrite, Penable, Hreadyout} !== 6'b010_1_0_0 || Pwdata !== 32'hDEAD_BEEF || Paddr !== 32'h8400_0020) begin
      miscompares++;
      $display("FAIL write_setup got sel=%b wr=%b en=%b rdy=%b pwdata=%h paddr=%h exp 010 1 0 0 deadbeef 84000020", Pselx, Pwrite, Penable, Hreadyout, Pwdata, Paddr);
    end
    step();
    Prdata = 32'h0000_0099;
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Penable, Hreadyout} !== 5'b010_1_1 || Hrdata !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL write_access got sel=%b en=%b rdy=%b hrdata=%h exp 010 1 1 000000a5", Pselx, Penable, Hreadyout, Hrdata);
    end
    step();
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1 || Hrdata !== 32'h0000_00A5 || Pwdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_idle got sel=%b en=%b rdy=%b hrdata=%h pwdata=%h exp 000 0 1 000000a5 deadbeef", Pselx, Penable, Hreadyout, Hrdata, Pwdata);
    end
  endtask

  task automatic test_back_to_back();
    step();
    Hvalid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8800_0000;
    step();
    // WWAIT: a new request must be ignored
    Hwrite = 1'b0; Haddr = 32'h8000_0100; Hwdata = 32'h1234_5678;
    step();
    // SETUP: toggle Hvalid with yet another address
    Hvalid = 1'b0; Haddr = 32'h8400_0100; Hwdata = 32'h0;
    @(negedge Hclk);
    vectors++;
    if (Pselx !== 3'b100 || Paddr !== 32'h8800_0000 || Pwdata !== 32'h1234_5678 || Penable !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_wsetup got sel=%b paddr=%h pwdata=%h en=%b exp 100 88000000 12345678 0", Pselx, Paddr, Pwdata, Penable);
    end
    step();
    Hvalid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0004; Prdata = 32'h0000_0055;
    @(negedge Hclk);
    vectors++;
    if (Paddr !== 32'h8800_0000 || {Pselx, Penable, Pwrite} !== 5'b100_1_1) begin
      miscompares++;
      $display("FAIL b2b_waccess got paddr=%h sel=%b en=%b wr=%b exp 88000000 100 1 1", Paddr, Pselx, Penable, Pwrite);
    end
    step();
    Hvalid = 1'b0;
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Penable, Pwrite, Hreadyout} !== 6'b001_0_0_0 || Paddr !== 32'h8000_0004) begin
      miscompares++;
      $display("FAIL b2b_rsetup got sel=%b en=%b wr=%b rdy=%b paddr=%h exp 001 0 0 0 80000004", Pselx, Penable, Pwrite, Hreadyout, Paddr);
    end
    step();
    @(negedge Hclk);
    vectors++;
    if (Penable !== 1'b1 || Hrdata !== 32'h0000_0055) begin
      miscompares++;
      $display("FAIL b2b_raccess got en=%b hrdata=%h exp 1 00000055", Penable, Hrdata);
    end
    step();
  endtask

  task automatic test_out_of_range();
    Hvalid = 1'b1; Hwrite = 1'b0; Haddr = 32'h9000_0000;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge Hclk);
      vectors++;
      if ({Pselx, Penable, Hreadyout} !== 5'b000_0_1) begin
        miscompares++;
        $display("FAIL oor_9000 cycle %0d got sel=%b en=%b rdy=%b exp 000 0 1", i, Pselx, Penable, Hreadyout);
      end
    end
    Haddr = 32'h8C00_0000;
    step();
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Hreadyout} !== 4'b000_1) begin
      miscompares++;
      $display("FAIL oor_8c00 got sel=%b rdy=%b exp 000 1", Pselx, Hreadyout);
    end
    Haddr = 32'h8BFF_FFFC;
    step();
    Hvalid = 1'b0;
    @(negedge Hclk);
    vectors++;
    if ({Pselx, Hreadyout} !== 4'b100_0 || Paddr !== 32'h8BFF_FFFC) begin
      miscompares++;
      $display("FAIL edge_8bff got sel=%b rdy=%b paddr=%h exp 100 0 8bfffffc", Pselx, Hreadyout, Paddr);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid_setup();
    Hvalid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0040;
    step();
    Hvalid = 1'b0; Hwrite = 1'b0; Hwdata = 32'hCAFE_F00D;
    step();
    @(negedge Hclk);
    vectors++;
    if (Pselx !== 3'b010 || Pwrite !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup_pre got sel=%b wr=%b exp 010 1", Pselx, Pwrite);
    end
    #1 Hresetn = 1'b0;
    #1;
    vectors++;
    if ({Hreadyout, Pselx, Penable, Pwrite} !== 6'b1_000_0_0) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl got rdy/sel/en/wr=%b%b%b%b exp 1 000 0 0", Hreadyout, Pselx, Penable, Pwrite);
    end
    vectors++;
    if ({Paddr, Pwdata, Hrdata} !== 96'h0) begin
      miscompares++;
      $display("FAIL mid_reset_data got paddr=%h pwdata=%h hrdata=%h exp 0", Paddr, Pwdata, Hrdata);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
    step();
    @(negedge Hclk);
    vectors++;
    if ({Hreadyout, Pselx, Penable} !== 5'b1_000_0) begin
      miscompares++;
      $display("FAIL post_reset_idle got rdy=%b sel=%b en=%b exp 1 000 0", Hreadyout, Pselx, Penable);
    end
  endtask

  initial begin
    Hresetn = 1'b0; Hvalid = 1'b0; Hwrite = 1'b0;
    Haddr = '0; Hwdata = '0; Prdata = '0;
    #12 Hresetn = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_setup();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
